// File: rtl/block_backlight_calc_if.sv
// Block-mean strobe input and backlight-map read port bundle.
// master: strobe source / LED driver side. slave: block_backlight_calc.
//   vs, block_mean_color, data_vaild, block_v_cnt : strobe side
//   rd_addr -> rd_data                            : map read port
//   frame_valid, frame_done, err_overflow         : status
interface block_backlight_calc_if #(
    parameter int ADDR_W = 10
);
    logic              vs;
    logic [23:0]       block_mean_color;
    logic              data_vaild;
    logic [5:0]        block_v_cnt;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic              frame_valid;
    logic              frame_done;
    logic              err_overflow;

    modport master (
        output vs,
        output block_mean_color,
        output data_vaild,
        output block_v_cnt,
        output rd_addr,
        input  rd_data,
        input  frame_valid,
        input  frame_done,
        input  err_overflow
    );

    modport slave (
        input  vs,
        input  block_mean_color,
        input  data_vaild,
        input  block_v_cnt,
        input  rd_addr,
        output rd_data,
        output frame_valid,
        output frame_done,
        output err_overflow
    );
endinterface

// File: rtl/block_backlight_calc.sv
// Per-block backlight level: weighted max/min, temporal IIR, double-buffered map.
// Ports: clk, rst (sync, active high), bus (block_backlight_calc_if.slave).
module block_backlight_calc #(
    parameter int BLOCK_H_NUM = 32,
    parameter int BLOCK_V_NUM = 18,
    parameter int ALPHA_SHIFT = 2,
    parameter int ADDR_W      = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    block_backlight_calc_if.slave bus
);
    // Power-of-two depth: every rd_addr value maps to a real entry.
    localparam int         DEPTH = 1 << ADDR_W;
    localparam logic [6:0] H_LIM = 7'(BLOCK_H_NUM);
    localparam logic [5:0] V_LIM = 6'(BLOCK_V_NUM);

    logic [7:0] map0 [DEPTH];
    logic [7:0] map1 [DEPTH];

    logic              vs_d;
    logic              vs_rise;
    logic [6:0]        col;
    logic [6:0]        cur_col;
    logic [5:0]        last_row;
    logic              drop;
    logic [ADDR_W-1:0] addr_c;

    logic              s0_vld;
    logic              s1_vld;
    logic              s2_vld;
    logic [23:0]       s0_color;
    logic [ADDR_W-1:0] s0_addr;
    logic [ADDR_W-1:0] s1_addr;
    logic [ADDR_W-1:0] s2_addr;
    logic [7:0]        s1_mx;
    logic [7:0]        s1_mn;
    logic [7:0]        s1_prev;
    logic [7:0]        s2_level;

    logic [7:0]        c_r;
    logic [7:0]        c_g;
    logic [7:0]        c_b;
    logic [7:0]        mx_c;
    logic [7:0]        mn_c;
    logic [7:0]        raw_c;
    logic [7:0]        iir_c;
    logic signed [8:0] diff_c;
    logic signed [8:0] step_c;

    logic bank_sel;
    logic first_frame;
    logic wr_seen;
    logic swap_pend;
    logic swap_req;
    logic pipe_busy;
    logic do_swap;
    logic swap_q;
    logic frame_valid_q;
    logic frame_done_q;
    logic err_q;
    logic [7:0] rd_q;

    assign vs_rise = bus.vs & ~vs_d;

    // Column restarts on a new frame or a new block row; the strobe
    // itself sees the restarted value.
    always_comb begin
        cur_col = col;
        if (vs_rise || (bus.block_v_cnt != last_row)) begin
            cur_col = '0;
        end
        drop   = (cur_col >= H_LIM) || (bus.block_v_cnt >= V_LIM);
        addr_c = ADDR_W'(13'(bus.block_v_cnt) * 13'(BLOCK_H_NUM)
                 + 13'(cur_col));
    end

    assign c_r = s0_color[23:16];
    assign c_g = s0_color[15:8];
    assign c_b = s0_color[7:0];

    always_comb begin
        mx_c = c_r;
        if (c_g > mx_c) mx_c = c_g;
        if (c_b > mx_c) mx_c = c_b;
        mn_c = c_r;
        if (c_g < mn_c) mn_c = c_g;
        if (c_b < mn_c) mn_c = c_b;
    end

    // A small positive error would shift to zero and never converge,
    // so rising steps are at least 1. Falling steps floor naturally.
    always_comb begin
        raw_c  = 8'((10'(s1_mx) * 10'd3 + 10'(s1_mn)) >> 2);
        diff_c = $signed({1'b0, raw_c}) - $signed({1'b0, s1_prev});
        step_c = diff_c >>> ALPHA_SHIFT;
        if ((diff_c > 9'sd0) && (step_c == 9'sd0)) begin
            step_c = 9'sd1;
        end
        iir_c = 8'({1'b0, s1_prev} + $unsigned(step_c));
    end

    // Swap waits for in-flight writes so they all land in the old back bank.
    assign pipe_busy = s0_vld | s1_vld | s2_vld;
    assign swap_req  = vs_rise | swap_pend;
    assign do_swap   = swap_req & ~pipe_busy & wr_seen;

    always_ff @(posedge clk) begin
        if (rst) begin
            vs_d          <= 1'b0;
            col           <= '0;
            last_row      <= '0;
            s0_vld        <= 1'b0;
            s1_vld        <= 1'b0;
            s2_vld        <= 1'b0;
            err_q         <= 1'b0;
            bank_sel      <= 1'b0;
            first_frame   <= 1'b1;
            wr_seen       <= 1'b0;
            swap_pend     <= 1'b0;
            swap_q        <= 1'b0;
            frame_valid_q <= 1'b0;
            frame_done_q  <= 1'b0;
            rd_q          <= '0;
        end else begin
            vs_d <= bus.vs;
            if (bus.data_vaild) begin
                col      <= (cur_col < H_LIM) ? cur_col + 7'd1 : cur_col;
                last_row <= bus.block_v_cnt;
            end else if (vs_rise) begin
                col <= '0;
            end
            s0_vld <= bus.data_vaild & ~drop;
            s1_vld <= s0_vld;
            s2_vld <= s1_vld;
            if (bus.data_vaild && drop) begin
                err_q <= 1'b1;
            end
            swap_pend <= swap_req & pipe_busy;
            if (do_swap) begin
                bank_sel      <= ~bank_sel;
                frame_valid_q <= 1'b1;
                first_frame   <= 1'b0;
                wr_seen       <= 1'b0;
            end else if (s2_vld) begin
                wr_seen <= 1'b1;
            end
            swap_q       <= do_swap;
            frame_done_q <= swap_q;
            if (frame_valid_q) begin
                rd_q <= bank_sel ? map1[bus.rd_addr] : map0[bus.rd_addr];
            end else begin
                rd_q <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        s0_color <= bus.block_mean_color;
        s0_addr  <= addr_c;
        s1_mx    <= mx_c;
        s1_mn    <= mn_c;
        s1_addr  <= s0_addr;
        s1_prev  <= bank_sel ? map1[s0_addr] : map0[s0_addr];
        s2_addr  <= s1_addr;
        s2_level <= first_frame ? raw_c : iir_c;
    end

    always_ff @(posedge clk) begin
        if (!rst && s2_vld) begin
            if (bank_sel) begin
                map0[s2_addr] <= s2_level;
            end else begin
                map1[s2_addr] <= s2_level;
            end
        end
    end

    assign bus.rd_data      = rd_q;
    assign bus.frame_valid  = frame_valid_q;
    assign bus.frame_done   = frame_done_q;
    assign bus.err_overflow = err_q;
endmodule
